// File: rtl/bp_mmio_arb_pkg.sv
// Shared types and helpers for the BlackParrot host MMIO arbiter slice.
// Optional build macro used by the top: BP_MMIO_ARB_TIMEOUT_EN.
package bp_mmio_arb_pkg;

    typedef enum logic [2:0] {
        e_idle  = 3'd0,
        e_addr  = 3'd1,
        e_data  = 3'd2,
        e_wresp = 3'd3,
        e_rresp = 3'd4
    } state_e;

    localparam int word_width_gp = 32;

    // Returned in place of host data when a read response never arrives.
    localparam logic [word_width_gp-1:0] timeout_data_gp = 32'hDEAD_BEEF;

    // Byte mask for a log2-bytes size code; code 3 is treated as a full word.
    function automatic logic [word_width_gp-1:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 32'h0000_00FF;
            2'd1:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/bp_mmio_host_arbiter_rr_arb.sv
// Round-robin requester pick; the search starts at a registered pointer that
// moves to one past the winner whenever a grant is taken.
module bp_mmio_rr_arb #(
    parameter int  num_req_p   = 4,
    localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [num_req_p-1:0]   v_i,
    input  logic                   grant_en_i,
    output logic [num_req_p-1:0]   grant_one_hot_o,
    output logic [id_width_lp-1:0] grant_id_o
);

    logic [id_width_lp-1:0] ptr_q, ptr_d;
    logic [id_width_lp-1:0] idx;
    logic                   found;

    always_comb begin
        grant_one_hot_o = '0;
        grant_id_o      = '0;
        found           = 1'b0;
        idx             = '0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = id_width_lp'((int'(ptr_q) + i) % num_req_p);
            if (!found && v_i[idx]) begin
                found                = 1'b1;
                grant_id_o           = idx;
                grant_one_hot_o[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_en_i && found) begin
            ptr_d = (int'(grant_id_o) == num_req_p - 1) ? '0 : grant_id_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bp_mmio_host_arbiter.sv
// Shares one host MMIO request/response FIFO pair between num_req_p requesters,
// one transaction in flight. Build macro BP_MMIO_ARB_TIMEOUT_EN adds a read timeout.
module bp_mmio_host_arbiter
    import bp_mmio_arb_pkg::*;
#(
    parameter int  num_req_p        = 4,
    parameter int  word_width_p     = 32,
    parameter int  timeout_cycles_p = 1024,
    localparam int id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [num_req_p-1:0]          req_v_i,
    input  logic [num_req_p*word_width_p-1:0] req_addr_i,
    input  logic [num_req_p*word_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]          req_w_i,
    input  logic [num_req_p*2-1:0]        req_size_i,
    output logic [num_req_p-1:0]          req_ready_and_o,
    output logic [num_req_p-1:0]          resp_v_o,
    output logic [word_width_p-1:0]       resp_data_o,
    output logic                          resp_w_o,
    input  logic [num_req_p-1:0]          resp_ready_and_i,
    output logic                          fifo_v_o,
    output logic [word_width_p-1:0]       fifo_data_o,
    input  logic                          fifo_ready_and_i,
    input  logic                          host_v_i,
    input  logic [word_width_p-1:0]       host_data_i,
    output logic                          host_yumi_o,
`ifdef BP_MMIO_ARB_TIMEOUT_EN
    output logic                          timeout_o,
`endif
    output logic [2:0]                    state_o,
    output logic                          busy_o,
    output logic [id_width_lp-1:0]        grant_id_o
);

    if (timeout_cycles_p < 2 || word_width_p != word_width_gp) begin : g_bad_params
        $error("bp_mmio_host_arbiter: unsupported parameter values");
    end

    state_e                 state_q, state_d;
    logic [id_width_lp-1:0] grant_q, grant_d;
    logic [num_req_p-1:0]   grant_oh_q, grant_oh_d;

    logic [num_req_p-1:0]   rr_oh;
    logic [id_width_lp-1:0] rr_id;

    bp_mmio_rr_arb #(.num_req_p(num_req_p)) rr_arb (
        .clk             (clk),
        .reset           (reset),
        .v_i             (req_v_i),
        .grant_en_i      (state_q == e_idle),
        .grant_one_hot_o (rr_oh),
        .grant_id_o      (rr_id)
    );

    // Fields of the locked requester; they are held stable until req_ready_and_o.
    logic [word_width_p-1:0] g_addr, g_data;
    logic [1:0]              g_size;
    logic                    g_w, g_resp_ready;

    assign g_addr       = req_addr_i[grant_q*word_width_p +: word_width_p];
    assign g_data       = req_data_i[grant_q*word_width_p +: word_width_p];
    assign g_size       = req_size_i[grant_q*2 +: 2];
    assign g_w          = req_w_i[grant_q];
    assign g_resp_ready = resp_ready_and_i[grant_q];

`ifdef BP_MMIO_ARB_TIMEOUT_EN
    localparam int timer_width_lp = $clog2(timeout_cycles_p);

    logic [timer_width_lp-1:0] timer_q, timer_d;
    logic                      timeout_q, timeout_d;
    logic                      timed_out;

    assign timed_out = (state_q == e_rresp) && !host_v_i
                    && (timer_q == timer_width_lp'(timeout_cycles_p - 1));
    assign timeout_o = timeout_q;
`endif

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        grant_oh_d      = grant_oh_q;
        fifo_v_o        = 1'b0;
        fifo_data_o     = '0;
        req_ready_and_o = '0;
        resp_v_o        = '0;
        resp_data_o     = '0;
        resp_w_o        = 1'b0;
        host_yumi_o     = 1'b0;
`ifdef BP_MMIO_ARB_TIMEOUT_EN
        timeout_d       = timeout_q;
        timer_d         = '0;
`endif
        case (state_q)
            e_idle: begin
                if (|req_v_i) begin
                    grant_d    = rr_id;
                    grant_oh_d = rr_oh;
                    state_d    = e_addr;
                end
            end
            e_addr: begin
                fifo_v_o    = 1'b1;
                fifo_data_o = g_addr;
                if (fifo_ready_and_i) state_d = e_data;
            end
            e_data: begin
                // Reads still send a data word so the host sees a fixed two-word frame.
                fifo_v_o    = 1'b1;
                fifo_data_o = g_w ? (g_data & size_mask(g_size)) : '0;
                if (fifo_ready_and_i) begin
                    req_ready_and_o = grant_oh_q;
                    state_d         = g_w ? e_wresp : e_rresp;
                end
            end
            e_wresp: begin
                resp_v_o = grant_oh_q;
                resp_w_o = 1'b1;
                if (g_resp_ready) state_d = e_idle;
            end
            e_rresp: begin
                resp_data_o = host_data_i;
                resp_v_o    = host_v_i ? grant_oh_q : '0;
                host_yumi_o = host_v_i & g_resp_ready;
                if (host_yumi_o) state_d = e_idle;
`ifdef BP_MMIO_ARB_TIMEOUT_EN
                if (!host_v_i && !timed_out) timer_d = timer_q + 1'b1;
                else                         timer_d = timer_q;
                if (timed_out) begin
                    resp_v_o    = grant_oh_q;
                    resp_data_o = timeout_data_gp;
                    if (g_resp_ready) begin
                        timeout_d = 1'b1;
                        state_d   = e_idle;
                    end
                end
`endif
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= e_idle;
            grant_q    <= '0;
            grant_oh_q <= '0;
`ifdef BP_MMIO_ARB_TIMEOUT_EN
            timer_q    <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
`ifdef BP_MMIO_ARB_TIMEOUT_EN
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign state_o    = state_q;
    assign busy_o     = (state_q != e_idle);
    assign grant_id_o = grant_q;

    // A requester may not withdraw its request before the data word is taken.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == e_addr || state_q == e_data)) begin
            req_held_a: assert (req_v_i[grant_q]);
        end
    end

endmodule

// File: tb/tb_bp_mmio_host_arbiter.sv
// Directed bench for bp_mmio_host_arbiter: inputs driven on the falling edge,
// outputs sampled 1ns later, expected values hand-computed per scenario.
module tb_bp_mmio_host_arbiter;

    localparam int N = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_DATA = 3'd2;
    localparam logic [2:0] S_WRESP = 3'd3, S_RRESP = 3'd4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_v, req_w, req_ready, resp_v, resp_ready;
    logic [N*32-1:0] req_addr, req_data;
    logic [N*2-1:0]  req_size;
    logic [31:0]   resp_data, fifo_data, host_data;
    logic          resp_w, fifo_v, fifo_ready, host_v, host_yumi, busy;
    logic [2:0]    state;
    logic [1:0]    grant_id;
`ifdef BP_MMIO_ARB_TIMEOUT_EN
    logic          timeout;
`endif

    int vectors = 0;
    int miscompares = 0;
    int yumi_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (host_yumi) yumi_cnt <= yumi_cnt + 1;

    bp_mmio_host_arbiter #(.num_req_p(N), .word_width_p(32), .timeout_cycles_p(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_v_i          (req_v),
        .req_addr_i       (req_addr),
        .req_data_i       (req_data),
        .req_w_i          (req_w),
        .req_size_i       (req_size),
        .req_ready_and_o  (req_ready),
        .resp_v_o         (resp_v),
        .resp_data_o      (resp_data),
        .resp_w_o         (resp_w),
        .resp_ready_and_i (resp_ready),
        .fifo_v_o         (fifo_v),
        .fifo_data_o      (fifo_data),
        .fifo_ready_and_i (fifo_ready),
        .host_v_i         (host_v),
        .host_data_i      (host_data),
        .host_yumi_o      (host_yumi),
`ifdef BP_MMIO_ARB_TIMEOUT_EN
        .timeout_o        (timeout),
`endif
        .state_o          (state),
        .busy_o           (busy),
        .grant_id_o       (grant_id)
    );

    task automatic idle_inputs();
        req_v = '0; req_w = '0; req_addr = '0; req_data = '0; req_size = '0;
        resp_ready = '1; fifo_ready = 1'b1; host_v = 1'b0; host_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advance at least one cycle, then until state_o matches; bounded.
    task automatic wait_state(input logic [2:0] s, output bit ok);
        int n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (state != s && n < 40);
        ok = (state == s);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic w, input logic [1:0] sz);
        req_addr[i*32 +: 32] = a;
        req_data[i*32 +: 32] = d;
        req_w[i]             = w;
        req_size[i*2 +: 2]   = sz;
        req_v[i]             = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1; req_v = '1; host_v = 1'b1; host_data = 32'h5555_AAAA;
        @(negedge clk); @(negedge clk); #1;
        vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want 0", state); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (fifo_v !== 1'b0 || fifo_data !== 32'h0) begin miscompares++; $display("FAIL rst_fifo: got v=%b d=%h want 0", fifo_v, fifo_data); end
        vectors++; if (resp_v !== 4'b0 || resp_data !== 32'h0 || resp_w !== 1'b0) begin miscompares++; $display("FAIL rst_resp: got v=%b d=%h w=%b want 0", resp_v, resp_data, resp_w); end
        vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        vectors++; if (host_yumi !== 1'b0) begin miscompares++; $display("FAIL rst_yumi: got %b want 0", host_yumi); end
        vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
`ifdef BP_MMIO_ARB_TIMEOUT_EN
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b want 0", timeout); end
`endif
    endtask

    task automatic test_read();
        bit ok;
        do_reset();
        set_req(1, 32'h0010_0004, 32'hFFFF_FFFF, 1'b0, 2'd2);
        wait_state(S_ADDR, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rd_reach_addr: got state %0d want 1", state); end
        vectors++; if (fifo_v !== 1'b1 || fifo_data !== 32'h0010_0004) begin miscompares++; $display("FAIL rd_addr_word: got v=%b d=%h want 1/00100004", fifo_v, fifo_data); end
        vectors++; if (grant_id !== 2'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL rd_grant: got id=%0d busy=%b want 1/1", grant_id, busy); end
        wait_state(S_DATA, ok);
        vectors++; if (!ok || fifo_data !== 32'h0) begin miscompares++; $display("FAIL rd_data_word: got st=%0d d=%h want 2/00000000", state, fifo_data); end
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL rd_req_ready: got %b want 0010", req_ready); end
        wait_state(S_RRESP, ok);
        req_v = '0; #1;
        vectors++; if (!ok || resp_v !== 4'b0 || host_yumi !== 1'b0) begin miscompares++; $display("FAIL rd_wait_host: got st=%0d v=%b y=%b want 4/0000/0", state, resp_v, host_yumi); end
        host_v = 1'b1; host_data = 32'h1234_5678; #1;
        vectors++; if (resp_v !== 4'b0010 || resp_data !== 32'h1234_5678 || resp_w !== 1'b0) begin miscompares++; $display("FAIL rd_resp: got v=%b d=%h w=%b want 0010/12345678/0", resp_v, resp_data, resp_w); end
        vectors++; if (host_yumi !== 1'b1) begin miscompares++; $display("FAIL rd_yumi: got %b want 1", host_yumi); end
        wait_state(S_IDLE, ok);
        host_v = 1'b0; #1;
        vectors++; if (!ok || busy !== 1'b0) begin miscompares++; $display("FAIL rd_back_idle: got st=%0d busy=%b want 0/0", state, busy); end
    endtask

    task automatic test_write();
        bit ok;
        int y0;
        logic [31:0] exp_word [4];
        exp_word = '{32'h0000_00DD, 32'h0000_CCDD, 32'hAABB_CCDD, 32'hAABB_CCDD};
        do_reset();
        host_v = 1'b1; host_data = 32'h0000_0055;
        y0 = yumi_cnt;
        for (int sz = 0; sz < 4; sz++) begin
            set_req(2, 32'h0000_0200 + 32'(sz), 32'hAABB_CCDD, 1'b1, 2'(sz));
            wait_state(S_ADDR, ok);
            vectors++; if (!ok || fifo_data !== 32'h0000_0200 + 32'(sz) || grant_id !== 2'd2) begin miscompares++; $display("FAIL wr_addr_sz%0d: got st=%0d d=%h id=%0d want 1/%h/2", sz, state, fifo_data, grant_id, 32'h200 + 32'(sz)); end
            wait_state(S_DATA, ok);
            vectors++; if (!ok || fifo_data !== exp_word[sz]) begin miscompares++; $display("FAIL wr_data_sz%0d: got %h want %h", sz, fifo_data, exp_word[sz]); end
            vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL wr_req_ready_sz%0d: got %b want 0100", sz, req_ready); end
            wait_state(S_WRESP, ok);
            req_v = '0; #1;
            vectors++; if (!ok || resp_v !== 4'b0100 || resp_w !== 1'b1 || resp_data !== 32'h0) begin miscompares++; $display("FAIL wr_ack_sz%0d: got v=%b w=%b d=%h want 0100/1/0", sz, resp_v, resp_w, resp_data); end
            vectors++; if (host_yumi !== 1'b0) begin miscompares++; $display("FAIL wr_ack_yumi_sz%0d: got %b want 0", sz, host_yumi); end
            wait_state(S_IDLE, ok);
            vectors++; if (!ok || host_yumi !== 1'b0) begin miscompares++; $display("FAIL wr_idle_yumi_sz%0d: got st=%0d y=%b want 0/0", sz, state, host_yumi); end
        end
        vectors++; if (yumi_cnt - y0 !== 0) begin miscompares++; $display("FAIL wr_host_untouched: got %0d consumes want 0", yumi_cnt - y0); end
        host_v = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int seq [6];
        logic [3:0] oh;
        seq = '{0, 1, 2, 3, 1, 3};
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h0000_1000 + 32'(i), 32'h0, 1'b1, 2'd2);
        for (int k = 0; k < 6; k++) begin
            oh = 4'b0001 << seq[k];
            wait_state(S_ADDR, ok);
            vectors++; if (!ok || grant_id !== 2'(seq[k]) || fifo_data !== 32'h0000_1000 + 32'(seq[k])) begin miscompares++; $display("FAIL rr_grant_%0d: got st=%0d id=%0d d=%h want id %0d", k, state, grant_id, fifo_data, seq[k]); end
            wait_state(S_DATA, ok);
            vectors++; if (!ok || req_ready !== oh) begin miscompares++; $display("FAIL rr_ready_%0d: got %b want %b", k, req_ready, oh); end
            wait_state(S_WRESP, ok);
            req_v[seq[k]] = 1'b0;
            if (k == 3) req_v = 4'b1010;
            #1;
            vectors++; if (!ok || resp_v !== oh) begin miscompares++; $display("FAIL rr_ack_%0d: got %b want %b", k, resp_v, oh); end
        end
        wait_state(S_IDLE, ok);
        vectors++; if (!ok || req_v !== 4'b0) begin miscompares++; $display("FAIL rr_drain: got st=%0d pending=%b want 0/0000", state, req_v); end
    endtask

    task automatic test_fifo_stall();
        bit ok;
        do_reset();
        set_req(3, 32'h0000_2000, 32'h1122_3344, 1'b1, 2'd2);
        wait_state(S_ADDR, ok);
        vectors++; if (!ok || fifo_data !== 32'h0000_2000 || grant_id !== 2'd3) begin miscompares++; $display("FAIL st_addr: got st=%0d d=%h id=%0d want 1/00002000/3", state, fifo_data, grant_id); end
        wait_state(S_DATA, ok);
        fifo_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++; if (state !== S_DATA || fifo_v !== 1'b1 || fifo_data !== 32'h1122_3344) begin miscompares++; $display("FAIL st_hold_%0d: got st=%0d v=%b d=%h want 2/1/11223344", i, state, fifo_v, fifo_data); end
            vectors++; if (req_ready !== 4'b0 || grant_id !== 2'd3) begin miscompares++; $display("FAIL st_grant_%0d: got rdy=%b id=%0d want 0000/3", i, req_ready, grant_id); end
            @(negedge clk);
        end
        fifo_ready = 1'b1; #1;
        vectors++; if (req_ready !== 4'b1000 || fifo_data !== 32'h1122_3344) begin miscompares++; $display("FAIL st_release: got rdy=%b d=%h want 1000/11223344", req_ready, fifo_data); end
        wait_state(S_WRESP, ok);
        req_v = '0;
        wait_state(S_IDLE, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL st_back_idle: got st=%0d want 0", state); end
    endtask

    task automatic test_resp_stall();
        bit ok;
        int y0;
        do_reset();
        set_req(0, 32'h0000_3000, 32'h0, 1'b0, 2'd2);
        wait_state(S_RRESP, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rs_reach_rresp: got st=%0d want 4", state); end
        req_v = '0; resp_ready[0] = 1'b0; host_v = 1'b1; host_data = 32'hCAFE_F00D;
        y0 = yumi_cnt;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (resp_v !== 4'b0001 || resp_data !== 32'hCAFE_F00D || host_yumi !== 1'b0) begin miscompares++; $display("FAIL rs_hold_%0d: got v=%b d=%h y=%b want 0001/cafef00d/0", i, resp_v, resp_data, host_yumi); end
            @(negedge clk);
        end
        resp_ready[0] = 1'b1; #1;
        vectors++; if (host_yumi !== 1'b1) begin miscompares++; $display("FAIL rs_consume: got %b want 1", host_yumi); end
        @(negedge clk); #1;
        vectors++; if (state !== S_IDLE || host_yumi !== 1'b0) begin miscompares++; $display("FAIL rs_after: got st=%0d y=%b want 0/0", state, host_yumi); end
        vectors++; if (yumi_cnt - y0 !== 1) begin miscompares++; $display("FAIL rs_single: got %0d consumes want 1", yumi_cnt - y0); end
        host_v = 1'b0;
    endtask

`ifdef BP_MMIO_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        do_reset();
        set_req(2, 32'h0000_4000, 32'h0, 1'b0, 2'd2);
        wait_state(S_RRESP, ok);
        req_v = '0; #1;
        n = 1;
        while (resp_v === 4'b0 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        vectors++; if (n != 16) begin miscompares++; $display("FAIL to_latency: got %0d cycles want 16", n); end
        vectors++; if (resp_v !== 4'b0100 || resp_data !== 32'hDEAD_BEEF || host_yumi !== 1'b0) begin miscompares++; $display("FAIL to_resp: got v=%b d=%h y=%b want 0100/deadbeef/0", resp_v, resp_data, host_yumi); end
        @(negedge clk); #1;
        vectors++; if (timeout !== 1'b1 || state !== S_IDLE) begin miscompares++; $display("FAIL to_sticky: got to=%b st=%0d want 1/0", timeout, state); end
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_fifo_stall();
        test_resp_stall();
`ifdef BP_MMIO_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
